// File: rtl/instr_prefetch.sv
// instr_prefetch: fetch PC walker with req/ack memory bus, prefetch FIFO and redirect flush.
module instr_prefetch #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [7:0]               mem_data,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [7:0]               instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [7:0]        data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [PW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop, done, issue;
    assign instr_valid = count_q != '0;
    assign instr       = data_q[rd_q];
    assign instr_pc    = pc_q[rd_q];
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign fifo_count  = count_q;
    // A request completes on ack in REQ/DROP; only a completed (or idle) bus may issue again.
    always_comb begin
        pop        = instr_valid && instr_ready && !redirect;
        push       = state_q == REQ && mem_ack && !redirect;
        count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
        fetch_pc_d = redirect ? redirect_pc : (push ? mem_addr_q + ADDR_W'(1) : fetch_pc_q);
        done       = state_q == IDLE || mem_ack;
        issue      = done && ena && count_d < CW'(DEPTH);
        state_d    = done ? (issue ? REQ : IDLE) : (redirect ? DROP : state_q);
        mem_addr_d = issue ? fetch_pc_d : mem_addr_q;
        mem_req_d  = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            rd_q       <= redirect ? '0 : rd_q + PW'(pop);
            wr_q       <= redirect ? '0 : wr_q + PW'(push);
            count_q    <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= mem_data;
            pc_q[wr_q]   <= mem_addr_q;
        end
    end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: directed scoreboard bench for instr_prefetch.
module tb_instr_prefetch;
    logic       clk = 1'b0;
    logic       rst, ena, mem_req, mem_ack, redirect, instr_valid, instr_ready, auto_ack, man_ack;
    logic [7:0] mem_addr, mem_data, redirect_pc, instr, instr_pc;
    logic [2:0] fifo_count;
    int         total = 0, passed = 0, failed = 0, nreq, n0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    // Memory model: either acks every request in the same cycle or follows man_ack.
    assign mem_ack  = auto_ack ? mem_req : man_ack;
    assign mem_data = mem_addr + 8'h21;

    instr_prefetch #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fifo_count(fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_seq(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] p;
            p = start + 8'(i);
            sb.push_back({p, p + 8'h21});
        end
    endtask

    // Compares the head against the scoreboard when a pop is about to happen, then advances one clock.
    task automatic cyc();
        #1;
        if (!rst && !redirect && instr_valid && instr_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                logic [15:0] e;
                e = sb.pop_front();
                check("instr_pc", instr_pc, e[15:8]);
                check("instr", instr, e[7:0]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        sb.delete();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; redirect = 1'b0; redirect_pc = '0;
        instr_ready = 1'b1; auto_ack = 1'b1; man_ack = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_cnt", fifo_count, 0);
        check("rst_valid", instr_valid, 0);

        // Zero-wait streaming
        rst = 1'b0;
        exp_seq(8'h00, 16);
        cyc();
        check("t1_req", mem_req, 1);
        check("t1_addr0", mem_addr, 0);
        check("t1_valid_late", instr_valid, 0);
        cyc();
        check("t1_valid", instr_valid, 1);
        check("t1_addr1", mem_addr, 1);
        for (int i = 2; i < 8; i++) begin
            cyc();
            check("t1_addr", mem_addr, 32'(i));
            check("t1_cnt", fifo_count, 1);
        end

        // Backpressure fills exactly DEPTH entries
        instr_ready = 1'b0;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req) begin
                check("t2_addr", mem_addr, 32'(nreq));
                nreq++;
            end
            cyc();
        end
        check("t2_nreq", nreq, 4);
        check("t2_cnt", fifo_count, 4);
        check("t2_req", mem_req, 0);
        check("t2_head", instr_pc, 0);
        exp_seq(8'h00, 16);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        check("t2_req4", mem_req, 1);
        check("t2_addr4", mem_addr, 4);
        check("t2_cnt3", fifo_count, 3);
        cyc();
        check("t2_cnt4", fifo_count, 4);
        check("t2_idle", mem_req, 0);
        cyc();
        cyc();
        check("t2_hold", mem_req, 0);
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();

        // Redirect while a slow request is outstanding
        auto_ack = 1'b0;
        man_ack = 1'b0;
        do_reset();
        exp_seq(8'h00, 2);
        cyc();
        check("t3_addr0", mem_addr, 0);
        man_ack = 1'b1;
        cyc();
        cyc();
        man_ack = 1'b0;
        check("t3_addr2", mem_addr, 2);
        cyc();
        check("t3_empty", fifo_count, 0);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        cyc();
        redirect = 1'b0;
        sb.delete();
        exp_seq(8'h40, 16);
        check("t3_drop_req", mem_req, 1);
        check("t3_drop_addr", mem_addr, 2);
        check("t3_drop_cnt", fifo_count, 0);
        cyc();
        check("t3_wait_req", mem_req, 1);
        check("t3_wait_addr", mem_addr, 2);
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        check("t3_new_addr", mem_addr, 8'h40);
        check("t3_new_req", mem_req, 1);
        check("t3_nopush", fifo_count, 0);
        check("t3_novalid", instr_valid, 0);
        auto_ack = 1'b1;
        cyc();
        check("t3_pc", instr_pc, 8'h40);
        check("t3_instr", instr, 8'h61);
        for (int i = 0; i < 3; i++) cyc();

        // Redirect coinciding with ack and pop
        check("t4_ack_pre", mem_ack, 1);
        check("t4_valid_pre", instr_valid, 1);
        redirect = 1'b1;
        redirect_pc = 8'h80;
        cyc();
        redirect = 1'b0;
        sb.delete();
        exp_seq(8'h80, 16);
        check("t4_cnt", fifo_count, 0);
        check("t4_valid", instr_valid, 0);
        check("t4_addr", mem_addr, 8'h80);
        check("t4_req", mem_req, 1);
        cyc();
        check("t4_pc", instr_pc, 8'h80);
        check("t4_instr", instr, 8'hA1);
        cyc();
        cyc();

        // PC wrap
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        cyc();
        redirect = 1'b0;
        sb.delete();
        exp_seq(8'hFE, 16);
        check("t5_addr", mem_addr, 8'hFE);
        n0 = sb.size();
        for (int i = 0; i < 6; i++) cyc();
        check("t5_popped", (n0 - sb.size()) >= 4, 1);
        check("t5_wrap_addr", mem_addr, 8'h04);

        // Enable drop, resume, then reset mid-request
        auto_ack = 1'b0;
        man_ack = 1'b0;
        do_reset();
        exp_seq(8'h00, 1);
        cyc();
        ena = 1'b0;
        cyc();
        cyc();
        check("t6_wait_req", mem_req, 1);
        check("t6_wait_addr", mem_addr, 0);
        man_ack = 1'b1;
        cyc();
        man_ack = 1'b0;
        check("t6_req", mem_req, 0);
        check("t6_cnt", fifo_count, 1);
        check("t6_pc", instr_pc, 0);
        cyc();
        check("t6_empty", fifo_count, 0);
        cyc();
        cyc();
        check("t6_noreq", mem_req, 0);
        ena = 1'b1;
        cyc();
        check("t6_resume_req", mem_req, 1);
        check("t6_resume_addr", mem_addr, 1);
        cyc();
        rst = 1'b1;
        man_ack = 1'b1;
        cyc();
        check("t6_rst_req", mem_req, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_cnt", fifo_count, 0);
        check("t6_rst_valid", instr_valid, 0);
        rst = 1'b0;
        sb.delete();
        cyc();
        check("t6_post_cnt", fifo_count, 0);
        check("t6_post_req", mem_req, 1);
        check("t6_post_addr", mem_addr, 0);
        man_ack = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
